// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// It holds the pipeline through stall_req and pulses result_valid when the quotient (LO) and remainder (HI) are ready.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall_req,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r, valid_r;

    logic             a_neg, b_neg, ge;
    logic [WIDTH-1:0] a_mag, b_mag, rem_nx, dvd_nx, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;

    // The magnitudes fit in WIDTH unsigned bits, because |MIN_INT| == 2^(WIDTH-1).
    // rem_sh carries the extra bit so the compare never overflows.
    always_comb begin
        a_neg  = signed_div & a[WIDTH-1];
        b_neg  = signed_div & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        rem_sh = {rem, dvd[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
        dvd_nx = {dvd[WIDTH-2:0], ge};
        q_fix  = sign_q ? -dvd_nx : dvd_nx;
        r_fix  = sign_r ? -rem_nx : rem_nx;
    end

    assign stall_req    = start & ~flush & (state != DONE);
    assign result_valid = valid_r & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            valid_r   <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (start) begin
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        rem    <= '0;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        cnt    <= '0;
                        // Divide by zero skips the iterations and is sign-agnostic.
                        if (b == '0) begin
                            quotient  <= '1;
                            remainder <= a;
                            valid_r   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        valid_r   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed/unsigned results, div-by-zero, flush, reset.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn, start, signed_div, flush;
    logic [W-1:0] a, b;
    logic         stall_req, result_valid;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .flush(flush), .a(a), .b(b), .stall_req(stall_req),
        .result_valid(result_valid), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold start until the DONE cycle, as the hazard unit would; the operands are scrambled after cycle 0.
    task automatic run_div(input string name, input logic sg, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r, input int exp_lat);
        int  stalls = 0;
        int  vcyc   = -1;
        logic [W-1:0] q_s, r_s;
        start = 1'b1; signed_div = sg; a = av; b = bv;
        for (int c = 0; c < 100 && vcyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk({name, " valid_at_start"}, {31'b0, result_valid}, 32'd0);
            if (stall_req) stalls++;
            if (result_valid) begin
                vcyc = c;
                q_s = quotient;
                r_s = remainder;
            end
            next_cycle();
            a = $urandom; b = $urandom; signed_div = ~sg;
        end
        start = 1'b0;
        chk({name, " latency"}, vcyc, exp_lat);
        chk({name, " stall_cycles"}, stalls, exp_lat);
        if (vcyc >= 0) begin
            chk({name, " q"}, q_s, exp_q);
            chk({name, " r"}, r_s, exp_r);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        next_cycle(); next_cycle();
        @(negedge clk);
        chk("reset q", quotient, 32'd0);
        chk("reset r", remainder, 32'd0);
        chk("reset valid", {31'b0, result_valid}, 32'd0);
        chk("reset stall", {31'b0, stall_req}, 32'd0);
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic test_unsigned();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33);
    endtask

    task automatic test_signed();
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    endtask

    task automatic test_div_zero();
        run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1);
        run_div("div_zero", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);
    endtask

    task automatic test_back_to_back();
        run_div("b2b_first", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 33);
        run_div("b2b_second", 1'b1, 32'hFFFFFFCE, 32'd6, 32'hFFFFFFF8, 32'hFFFFFFFE, 33);
    endtask

    task automatic test_flush();
        int seen = 0;
        run_div("pre_flush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        for (int c = 0; c < 10; c++) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall", {31'b0, stall_req}, 32'd0);
        next_cycle();
        // start and flush together in IDLE must not launch a divide.
        @(negedge clk);
        chk("flush_start stall", {31'b0, stall_req}, 32'd0);
        next_cycle();
        start = 1'b0; flush = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid || stall_req) seen++;
            next_cycle();
        end
        chk("flush no_valid", seen, 32'd0);
        chk("flush q_hold", quotient, 32'd14);
        chk("flush r_hold", remainder, 32'd2);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd7;
        for (int c = 0; c < 5; c++) next_cycle();
        resetn = 1'b0; start = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("midrst q", quotient, 32'd0);
        chk("midrst r", remainder, 32'd0);
        chk("midrst valid", {31'b0, result_valid}, 32'd0);
        chk("midrst stall", {31'b0, stall_req}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        run_div("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
